pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 9'd0: first fetch address after start.
REQ-002 SHALL have parameter FETCH_CYCLES, default 3: cycles each PC is held for the downstream instruction-fetch controller; legal range 1..7.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port start, input, 1: IDLE->RUN request.
REQ-006 SHALL have port stall, input, 1: freeze PC and hold counter.
REQ-007 SHALL have port redirect, input, 1: branch/jump request.
REQ-008 SHALL have port redirect_pc, input, 9: redirect target address.
REQ-009 SHALL have port halt_req, input, 1: stop fetching.
REQ-010 SHALL have port pc, output, 9: current fetch address, drives the controller PC input.
REQ-011 SHALL have port fetch_en, output, 1: drives the controller enable; high only in RUN.
REQ-012 SHALL have port hold_cnt, output, 3: cycle index within the current PC hold.
REQ-013 SHALL have port instr_cnt, output, 16: number of PCs completed.
REQ-014 SHALL have port state, output, 2: 00 IDLE, 01 RUN, 10 HALT.

Function
REQ-015 SHALL implement a three-state FSM (IDLE, RUN, HALT), registered; encoding per REQ-014.
REQ-016 SHALL go IDLE->RUN on the edge where start=1, loading pc=RESET_PC and hold_cnt=0; fetch_en=1 from the following cycle.
REQ-017 SHALL, in RUN with stall=0, increment hold_cnt each cycle; at hold_cnt=FETCH_CYCLES-1 it returns to 0 and pc advances (boundary edge).
REQ-018 SHALL advance pc at a boundary to the pending or current redirect target if one exists, else pc+1 modulo 512 (511->0).
REQ-019 SHALL latch redirect_pc into a one-entry pending buffer when redirect=1 on a non-boundary cycle; a later redirect before the boundary overwrites it; the buffer clears when consumed.
REQ-020 SHALL give a redirect asserted on the boundary cycle itself priority over the pending buffer, and clear the buffer.
REQ-021 SHALL, while stall=1 in RUN, hold pc and hold_cnt unchanged and keep fetch_en=1; redirect is still latched into the pending buffer.
REQ-022 SHALL increment instr_cnt by 1 at each boundary, saturating at 16'hFFFF.
REQ-023 SHALL go RUN->HALT on the edge where halt_req=1, regardless of stall or redirect, and take priority over them; pc, hold_cnt and instr_cnt freeze, fetch_en=0 next cycle, pending buffer cleared.
REQ-024 SHALL stay in HALT until rst; start is ignored in HALT and RUN.
REQ-025 SHALL ignore stall, redirect and halt_req in IDLE.
REQ-026 SHALL apply priority halt_req > stall > boundary/increment within RUN.

Reset
REQ-027 SHALL, on rst=1 (asynchronous, any cycle, including mid-hold or mid-redirect), immediately force state=IDLE, pc=RESET_PC, hold_cnt=0, instr_cnt=0, fetch_en=0, and clear the pending buffer.
REQ-028 SHALL resume normal operation only on the first rising clk edge after rst deasserts.

Verification
REQ-029 SHALL be checked for a basic run: rst pulse, start at t0 -> pc=0 for 3 cycles, then 1, 2; instr_cnt=2 after 6 RUN cycles; fetch_en=1 throughout.
REQ-030 SHALL be checked for wrap: RESET_PC=9'd510 -> pc sequence 510, 511, 0, 1, each held 3 cycles.
REQ-031 SHALL be checked for redirect buffering: redirect=1, redirect_pc=9'd100 at hold_cnt=0, then redirect_pc=9'd200 at hold_cnt=1 -> next pc=200; a redirect to 9'd50 on the boundary with pending 200 -> next pc=50.
REQ-032 SHALL be checked for stall: stall=1 for 4 cycles at hold_cnt=1 -> pc and hold_cnt frozen 4 cycles; the boundary is delayed by exactly 4 cycles.
REQ-033 SHALL be checked for halt: halt_req with stall=1 and redirect=1 in the same cycle -> state=HALT, fetch_en=0, pc unchanged; later start is ignored.
REQ-034 SHALL be checked for async reset mid-hold: rst asserted between edges at hold_cnt=2 -> outputs reach reset values before the next edge; start then restarts at RESET_PC.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds each fetch address for FETCH_CYCLES cycles,
// then advances sequentially or to a redirect target, with stall and halt control.
module pc_sequencer #(
  parameter logic [8:0] RESET_PC     = 9'd0,
  parameter int         FETCH_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stall,
  input  logic       redirect,
  input  logic [8:0] redirect_pc,
  input  logic       halt_req,
  output logic [8:0] pc,
  output logic       fetch_en,
  output logic [2:0] hold_cnt,
  output logic [15:0] instr_cnt,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } state_t;

  localparam logic [2:0] HOLD_LAST = 3'(FETCH_CYCLES - 1);

  state_t      state_q, state_n;
  logic [8:0]  pc_q, pc_n;
  logic [2:0]  hold_q, hold_n;
  logic [15:0] icnt_q, icnt_n;
  logic        pend_vld_q, pend_vld_n;
  logic [8:0]  pend_pc_q, pend_pc_n;
  logic        boundary;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Sequential successor; 9-bit arithmetic gives the 511 -> 0 wrap.
  function automatic logic [8:0] next_seq_pc(input logic [8:0] v);
    return v + 9'd1;
  endfunction

  assign boundary = (hold_q == HOLD_LAST);

  always_comb begin
    state_n    = state_q;
    pc_n       = pc_q;
    hold_n     = hold_q;
    icnt_n     = icnt_q;
    pend_vld_n = pend_vld_q;
    pend_pc_n  = pend_pc_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_n    = S_RUN;
          pc_n       = RESET_PC;
          hold_n     = 3'd0;
          pend_vld_n = 1'b0;
        end
      end
      S_RUN: begin
        if (halt_req) begin
          state_n    = S_HALT;
          pend_vld_n = 1'b0;
        end else if (stall) begin
          if (redirect) begin
            pend_vld_n = 1'b1;
            pend_pc_n  = redirect_pc;
          end
        end else if (boundary) begin
          // A redirect arriving on the boundary itself beats the buffered one.
          hold_n     = 3'd0;
          icnt_n     = sat_inc16(icnt_q);
          pend_vld_n = 1'b0;
          if (redirect)
            pc_n = redirect_pc;
          else if (pend_vld_q)
            pc_n = pend_pc_q;
          else
            pc_n = next_seq_pc(pc_q);
        end else begin
          hold_n = hold_q + 3'd1;
          if (redirect) begin
            pend_vld_n = 1'b1;
            pend_pc_n  = redirect_pc;
          end
        end
      end
      S_HALT: begin
        state_n = S_HALT;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      hold_q     <= 3'd0;
      icnt_q     <= 16'd0;
      pend_vld_q <= 1'b0;
      pend_pc_q  <= 9'd0;
    end else begin
      state_q    <= state_n;
      pc_q       <= pc_n;
      hold_q     <= hold_n;
      icnt_q     <= icnt_n;
      pend_vld_q <= pend_vld_n;
      pend_pc_q  <= pend_pc_n;
    end
  end

  assign pc        = pc_q;
  assign hold_cnt  = hold_q;
  assign instr_cnt = icnt_q;
  assign state     = state_q;
  assign fetch_en  = (state_q == S_RUN);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: default instance plus a RESET_PC=510 instance for wrap.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, stall, redirect, halt_req;
  logic [8:0]  redirect_pc;
  logic [8:0]  pc;
  logic        fetch_en;
  logic [2:0]  hold_cnt;
  logic [15:0] instr_cnt;
  logic [1:0]  state;

  logic        rst_w, start_w;
  logic        stall_w, redirect_w, halt_w;
  logic [8:0]  redirect_pc_w;
  logic [8:0]  pc_w;
  logic        fetch_en_w;
  logic [2:0]  hold_cnt_w;
  logic [15:0] instr_cnt_w;
  logic [1:0]  state_w;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt_req(halt_req), .pc(pc), .fetch_en(fetch_en),
    .hold_cnt(hold_cnt), .instr_cnt(instr_cnt), .state(state)
  );

  pc_sequencer #(.RESET_PC(9'd510), .FETCH_CYCLES(3)) dut_w (
    .clk(clk), .rst(rst_w), .start(start_w), .stall(stall_w), .redirect(redirect_w),
    .redirect_pc(redirect_pc_w), .halt_req(halt_w), .pc(pc_w), .fetch_en(fetch_en_w),
    .hold_cnt(hold_cnt_w), .instr_cnt(instr_cnt_w), .state(state_w)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic [8:0] p,
                         input logic [2:0] h, input logic [15:0] ic, input logic fe);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".pc"}, 32'(pc), 32'(p));
    chk({tag, ".hold"}, 32'(hold_cnt), 32'(h));
    chk({tag, ".icnt"}, 32'(instr_cnt), 32'(ic));
    chk({tag, ".fe"}, 32'(fetch_en), 32'(fe));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; redirect = 1'b0; halt_req = 1'b0;
    redirect_pc = 9'd0;
    rst_w = 1'b1; start_w = 1'b0; stall_w = 1'b0; redirect_w = 1'b0; halt_w = 1'b0;
    redirect_pc_w = 9'd0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk_all("reset", 2'b00, 9'd0, 3'd0, 16'd0, 1'b0);

    // IDLE ignores stall/redirect/halt
    stall = 1'b1; redirect = 1'b1; redirect_pc = 9'd33; halt_req = 1'b1;
    tick();
    chk_all("idle_ignore", 2'b00, 9'd0, 3'd0, 16'd0, 1'b0);
    stall = 1'b0; redirect = 1'b0; halt_req = 1'b0;

    // Basic run
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("start", 2'b01, 9'd0, 3'd0, 16'd0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("run.pc", 32'(pc), 32'((i + 1) / 3));
      chk("run.hold", 32'(hold_cnt), 32'((i + 1) % 3));
      chk("run.fe", 32'(fetch_en), 32'd1);
    end
    chk_all("run6", 2'b01, 9'd2, 3'd0, 16'd2, 1'b1);

    // Pending redirect overwritten before the boundary
    redirect = 1'b1; redirect_pc = 9'd100;
    tick();
    redirect_pc = 9'd200;
    tick();
    redirect = 1'b0;
    chk_all("redir_pend", 2'b01, 9'd2, 3'd2, 16'd2, 1'b1);
    tick();
    chk_all("redir_200", 2'b01, 9'd200, 3'd0, 16'd3, 1'b1);

    // Boundary redirect beats pending buffer, then buffer is empty
    redirect = 1'b1; redirect_pc = 9'd200;
    tick();
    redirect = 1'b0;
    tick();
    redirect = 1'b1; redirect_pc = 9'd50;
    tick();
    redirect = 1'b0;
    chk_all("redir_50", 2'b01, 9'd50, 3'd0, 16'd4, 1'b1);
    tick(); tick(); tick();
    chk_all("after_50", 2'b01, 9'd51, 3'd0, 16'd5, 1'b1);

    // Stall 4 cycles at hold_cnt=1; redirect latched during stall
    tick();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin redirect = 1'b1; redirect_pc = 9'd300; end
      tick();
      chk("stall.pc", 32'(pc), 32'd51);
      chk("stall.hold", 32'(hold_cnt), 32'd1);
      chk("stall.fe", 32'(fetch_en), 32'd1);
    end
    stall = 1'b0; redirect = 1'b0;
    tick();
    chk_all("post_stall", 2'b01, 9'd51, 3'd2, 16'd5, 1'b1);
    tick();
    chk_all("stall_bnd", 2'b01, 9'd300, 3'd0, 16'd6, 1'b1);

    // Halt wins over stall and redirect
    tick();
    halt_req = 1'b1; stall = 1'b1; redirect = 1'b1; redirect_pc = 9'd77;
    tick();
    halt_req = 1'b0; stall = 1'b0; redirect = 1'b0;
    chk_all("halt", 2'b10, 9'd300, 3'd1, 16'd6, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk_all("halt_start", 2'b10, 9'd300, 3'd1, 16'd6, 1'b0);

    // Async reset mid-hold
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all("rst_halt", 2'b00, 9'd0, 3'd0, 16'd0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk_all("pre_arst", 2'b01, 9'd1, 3'd2, 16'd1, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk_all("arst", 2'b00, 9'd0, 3'd0, 16'd0, 1'b0);
    #1 rst = 1'b0;
    tick();
    chk_all("arst_idle", 2'b00, 9'd0, 3'd0, 16'd0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("restart", 2'b01, 9'd0, 3'd0, 16'd0, 1'b1);

    // Wrap instance: 510, 511, 0, 1 each held 3 cycles
    rst_w = 1'b0;
    tick();
    chk("wrap.idle_pc", 32'(pc_w), 32'd510);
    start_w = 1'b1;
    tick();
    start_w = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("wrap.pc", 32'(pc_w), 32'((510 + i / 3) % 512));
      chk("wrap.hold", 32'(hold_cnt_w), 32'(i % 3));
      tick();
    end
    chk("wrap.icnt", 32'(instr_cnt_w), 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
